branch_update_unit: RTL
=======================

// Module: branch_update_unit
// PURPOSE
//  Producer side of the branch-predictor update path. Accepts resolved branches from EX, queues them,
//  and drives write ports of the BHT (history shift) and the PHT (2-bit counter read-modify-write).
//  Sits between EX resolution and the predictor tables; decouples EX from table-port timing and stalls.
// PARAMETERS
//  IDX_W    8   BHT index width; also PHT index width
//  BHR_W    8   branch history register width (must be >= IDX_W)
//  DEPTH    4   update FIFO entries (power of 2, >= 2)
// PORTS
//  clk          in   1      clock, rising edge
//  resetn       in   1      asynchronous, active-low reset
//  stall        in   1      pipeline stall: freezes FIFO pop and both update stages
//  in_valid     in   1      resolved branch presented by EX
//  in_ready     out  1      FIFO can accept (not full)
//  in_bht_idx   in   IDX_W  BHT index used at prediction time
//  in_bhr       in   BHR_W  BHR snapshot used at prediction time
//  in_taken     in   1      resolved direction
//  bht_we       out  1      BHT write enable
//  bht_waddr    out  IDX_W  BHT write index
//  bht_wdata    out  BHR_W  {bhr[BHR_W-2:0], taken}
//  pht_raddr    out  IDX_W  PHT read index (synchronous RAM, data next cycle)
//  pht_rdata    in   2      PHT counter read data, valid one cycle after pht_raddr
//  pht_we       out  1      PHT write enable
//  pht_waddr    out  IDX_W  PHT write index
//  pht_wdata    out  2      updated counter
//  busy         out  1      FIFO non-empty or any stage valid
// BEHAVIOUR
//  - Reset: FIFO empty, stages invalid; bht_we=pht_we=0, addresses/data 0, in_ready=1, busy=0.
//    Reset mid-operation drops all queued/in-flight updates; no partial write is issued.
//  - Push when in_valid & in_ready. in_ready = !full; push while full is refused even if a pop occurs
//    the same cycle. in_ready is independent of stall.
//  - PHT index = in_bht_idx ^ in_bhr[IDX_W-1:0], computed at push and stored with the entry.
//  - Stage RD (cycle of pop, !stall, FIFO non-empty): pht_raddr=entry PHT index; bht_we=1 with
//    bht_waddr=entry bht_idx, bht_wdata=shifted snapshot. Entry moves to stage WB next cycle.
//  - Stage WB: cnt = forward ? last_pht_wdata : pht_rdata; pht_we=1, pht_waddr=index,
//    pht_wdata = taken ? (cnt==3 ? 3 : cnt+1) : (cnt==0 ? 0 : cnt-1). Saturating, 2-bit only.
//  - Forwarding: forward=1 when a PHT write to the same index occurred in the previous cycle
//    (read-during-write returns old data). Back-to-back same-index updates must compose.
//  - One pop per cycle max; RD and WB overlap, sustained throughput 1 update/cycle.
//  - stall=1: no pop, no stage advance, bht_we=pht_we=0; WB entry holds and its write is issued
//    (re-reading pht_raddr of held index first) in the first non-stall cycle; push still allowed.
//  - Latency (no bypass): push at t -> bht_we at t+1 -> pht_we at t+2.
//  - FIFO pointers wrap modulo DEPTH; full/empty via count, count width $clog2(DEPTH)+1.
// CONFIGURATION
//  BRANCH_UPDATE_BYPASS_EN defined: when FIFO empty, !stall and push, entry enters RD in the push
//  cycle (bht_we at t, pht_we at t+1) without occupying the FIFO.
//  Undefined: every entry passes through the FIFO; latency as above.
// STRUCTURE
//  - defines.v: IDX_W/BHR_W defaults, PHT counter encodings (SNT=0,WNT=1,WT=2,ST=3).
//  - Sub-module branch_update_fifo: DEPTH-entry sync FIFO, async active-low reset, push/pop/full/empty.
//  - Top: RD/WB stage registers, forwarding compare, counter update, stall gating.
// TESTING
//  1 Reset: resetn=0 mid-traffic -> all write enables 0 immediately, in_ready=1, busy=0 after release.
//  2 Single update idx=0x12,bhr=0x05,taken=1,pht_rdata=1 -> bht_waddr=0x12,bht_wdata=0x0B at t+1;
//    pht_waddr=0x17,pht_wdata=2 at t+2.
//  3 Saturation: rdata=3 taken -> 3; rdata=0 not-taken -> 0.
//  4 Back-to-back 3 taken updates same PHT index, RAM returns stale 1 -> writes 2,3,3.
//  5 Full: hold stall=1, push 5 -> in_ready=0 after 4th; release -> 4 updates drained in order.
//  6 Bypass build: empty FIFO, push at t -> bht_we at t, pht_we at t+1; non-bypass build t+1/t+2.

Source files
------------

// File: rtl/branch_update_pkg.sv
// Shared definitions for the branch-predictor update path: default widths,
// 2-bit PHT counter encodings and the saturating counter update.
package branch_update_pkg;

    localparam int IDX_W_DEF = 8;
    localparam int BHR_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        PHT_SNT = 2'd0,
        PHT_WNT = 2'd1,
        PHT_WT  = 2'd2,
        PHT_ST  = 2'd3
    } pht_cnt_e;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == PHT_ST) ? PHT_ST : cnt + 2'd1;
        end else begin
            res = (cnt == PHT_SNT) ? PHT_SNT : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// DEPTH-entry synchronous FIFO holding resolved branches awaiting table update.
// Push is refused while full, even when a pop happens in the same cycle.
module branch_update_fifo
    import branch_update_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: the data array has no reset; empty/full come from count, so stale contents are never consumed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/branch_update_unit.sv
// Branch-predictor update producer: queues resolved branches from EX and
// drives the BHT write port (history shift) and PHT read-modify-write of the
// 2-bit counters. Two overlapping stages: RD (pop, BHT write, PHT read) and
// WB (counter update, PHT write) with same-index forwarding.
// Optional feature: define BRANCH_UPDATE_BYPASS_EN to let a push into an
// empty FIFO enter RD in the push cycle without occupying the FIFO.
module branch_update_unit
    import branch_update_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int BHR_W = BHR_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_bht_idx,
    input  logic [BHR_W-1:0] in_bhr,
    input  logic             in_taken,
    output logic             bht_we,
    output logic [IDX_W-1:0] bht_waddr,
    output logic [BHR_W-1:0] bht_wdata,
    output logic [IDX_W-1:0] pht_raddr,
    input  logic [1:0]       pht_rdata,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_waddr,
    output logic [1:0]       pht_wdata,
    output logic             busy
);

    // Entry layout: {pht_idx, bht_idx, hist}; hist is the shifted BHR whose
    // LSB is the resolved direction, so taken needs no separate field.
    localparam int ENT_W = 2 * IDX_W + BHR_W;

    logic             push_ok;
    logic             bypass_take;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             rd_active;
    logic [ENT_W-1:0] in_entry;
    logic [ENT_W-1:0] head_entry;
    logic [ENT_W-1:0] rd_entry;
    logic [IDX_W-1:0] rd_pht_idx;
    logic [IDX_W-1:0] rd_bht_idx;
    logic [BHR_W-1:0] rd_hist;

    logic             wb_valid;
    logic [IDX_W-1:0] wb_pht_idx;
    logic             wb_taken;

    logic             last_we;
    logic [IDX_W-1:0] last_waddr;
    logic [1:0]       last_wdata;
    logic             forward;
    logic [1:0]       cnt;

    assign in_ready = ~fifo_full;
    assign push_ok  = in_valid & in_ready;
    assign in_entry = {in_bht_idx ^ in_bhr[IDX_W-1:0], in_bht_idx,
                       in_bhr[BHR_W-2:0], in_taken};

`ifdef BRANCH_UPDATE_BYPASS_EN
    // Gated by resetn so no write enable can escape while reset is held.
    assign bypass_take = resetn & push_ok & fifo_empty & ~stall;
`else
    assign bypass_take = 1'b0;
`endif

    assign fifo_push = push_ok & ~bypass_take;
    assign fifo_pop  = ~stall & ~fifo_empty;
    assign rd_active = fifo_pop | bypass_take;
    assign rd_entry  = bypass_take ? in_entry : head_entry;
    assign {rd_pht_idx, rd_bht_idx, rd_hist} = rd_entry;

    branch_update_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .wdata  (in_entry),
        .pop    (fifo_pop),
        .rdata  (head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // RD -> WB stage register; frozen while stalled so the WB entry is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid   <= 1'b0;
            wb_pht_idx <= '0;
            wb_taken   <= 1'b0;
        end else if (!stall) begin
            wb_valid <= rd_active;
            if (rd_active) begin
                wb_pht_idx <= rd_pht_idx;
                wb_taken   <= rd_hist[0];
            end
        end
    end

    // Remember last cycle's PHT write; the RAM returns old data on read-during-write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_we    <= 1'b0;
            last_waddr <= '0;
            last_wdata <= '0;
        end else begin
            last_we    <= pht_we;
            last_waddr <= pht_waddr;
            last_wdata <= pht_wdata;
        end
    end

    assign forward = last_we && (last_waddr == wb_pht_idx);
    assign cnt     = forward ? last_wdata : pht_rdata;

    // Port drive for both stages; idle ports present zero.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        bht_we    = 1'b0;
        bht_waddr = '0;
        bht_wdata = '0;
        pht_raddr = '0;
        pht_we    = 1'b0;
        pht_waddr = '0;
        pht_wdata = '0;

        if (stall && wb_valid) begin
            // Re-read the held index so fresh data is ready when the stall lifts.
            pht_raddr = wb_pht_idx;
        end else if (rd_active) begin
            pht_raddr = rd_pht_idx;
        end

        if (rd_active) begin
            bht_we    = 1'b1;
            bht_waddr = rd_bht_idx;
            bht_wdata = rd_hist;
        end

        if (wb_valid && !stall) begin
            pht_we    = 1'b1;
            pht_waddr = wb_pht_idx;
            pht_wdata = pht_next(cnt, wb_taken);
        end
    end

    assign busy = ~fifo_empty | rd_active | wb_valid;

endmodule
